seg7_scan_driver: RTL and testbench

//  Displays the MAC accumulator value on the board's multiplexed 4-digit 7-segment display as decimal.
//  It is the stage directly downstream of clkdiv and consumes its divided clk_out as the scan strobe.

---
 rtl/seg7_pkg.sv | 63 ++++++
 rtl/bin2bcd_seq.sv | 163 ++++++++++++++++
 rtl/seg7_scan_driver.sv | 121 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared definitions for the 7-segment scan driver.
//                Active-low segment encodings {g,f,e,d,c,b,a}, the
//                conversion FSM state type, and a helper that sizes the
//                BCD scratch register for a given binary width.
//  Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    // Active-low segment pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Number of decimal digits needed to hold 2^width-1 without truncation.
    function automatic int bcd_nibbles(input int width);
        longint unsigned max_val;
        longint unsigned pow;
        int              n;
        max_val = (64'd1 << width) - 64'd1;
        pow     = 64'd10;
        n       = 1;
        for (int i = 0; i < 20; i++) begin
            if (pow <= max_val) begin
                n   = n + 1;
                pow = pow * 64'd10;
            end
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble binary-to-BCD converter with a
//                one-deep pending slot. One shift per clock; a strobe that
//                arrives while busy is parked and converted next.
//  Ports       : clk_in  - clock
//                reset   - synchronous active-high reset
//                start   - 1-cycle load strobe for value
//                value   - binary input
//                busy    - conversion in progress
//                done    - 1-cycle pulse while the result in bcd is final
//                bcd     - low DIGITS BCD nibbles of the result
//                ovf     - last converted value exceeded 10^DIGITS-1
//  Revision    : 1.0  initial release
// ============================================================================
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int VALUE_W = 16,
    parameter int DIGITS  = 4
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  start,
    input  logic [VALUE_W-1:0]    value,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd,
    output logic                  ovf
);

    localparam int c_NIBBLES = bcd_nibbles(VALUE_W);
    localparam int c_SR_W    = c_NIBBLES * 4 + VALUE_W;
    localparam int c_CNT_W   = $clog2(VALUE_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(VALUE_W - 1);

    conv_state_t            r_state;
    conv_state_t            w_state_next;
    logic [c_SR_W-1:0]      r_sr;        // {bcd scratch, binary}
    logic [c_SR_W-1:0]      w_sr_adj;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_pending;
    logic [VALUE_W-1:0]     r_pend_val;
    logic                   r_ovf;
    logic                   w_load_new;
    logic                   w_load_pend;
    logic                   w_store_pend;
    logic                   w_done;
    logic                   w_hi_nz;

    // State register
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control strobes
    always_comb begin
        w_state_next = r_state;
        w_load_new   = 1'b0;
        w_load_pend  = 1'b0;
        w_store_pend = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load_new   = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_store_pend = start;
                if (r_cnt == c_LAST) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                if (r_pending) begin
                    // Older parked value goes first; a simultaneous strobe
                    // takes its place in the pending slot.
                    w_load_pend  = 1'b1;
                    w_store_pend = start;
                    w_state_next = ST_SHIFT;
                end else if (start) begin
                    // Equivalent to parking and immediately reloading.
                    w_load_new   = 1'b1;
                    w_state_next = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Add-3 correction on every nibble >= 5 before the shift.
    always_comb begin
        w_sr_adj = r_sr;
        for (int i = 0; i < c_NIBBLES; i++) begin
            if (r_sr[VALUE_W + 4*i +: 4] >= 4'd5) begin
                w_sr_adj[VALUE_W + 4*i +: 4] = r_sr[VALUE_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Datapath
    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_sr       <= '0;
            r_cnt      <= '0;
            r_pending  <= 1'b0;
            r_pend_val <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_load_new) begin
                r_sr  <= {{(c_NIBBLES*4){1'b0}}, value};
                r_cnt <= '0;
            end else if (w_load_pend) begin
                r_sr  <= {{(c_NIBBLES*4){1'b0}}, r_pend_val};
                r_cnt <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_sr  <= {w_sr_adj[c_SR_W-2:0], 1'b0};
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_store_pend) begin
                r_pending  <= 1'b1;
                r_pend_val <= value;
            end else if (w_load_pend) begin
                r_pending  <= 1'b0;
            end

            if (w_done) begin
                r_ovf <= w_hi_nz;
            end
        end
    end

    // Overflow means a nonzero nibble above the displayed digits.
    generate
        if (c_NIBBLES > DIGITS) begin : g_ovf_chk
            assign w_hi_nz = |r_sr[c_SR_W-1:VALUE_W + DIGITS*4];
            assign bcd     = r_sr[VALUE_W +: DIGITS*4];
        end else if (c_NIBBLES == DIGITS) begin : g_exact
            assign w_hi_nz = 1'b0;
            assign bcd     = r_sr[c_SR_W-1:VALUE_W];
        end else begin : g_pad
            assign w_hi_nz = 1'b0;
            assign bcd     = {{((DIGITS - c_NIBBLES)*4){1'b0}}, r_sr[c_SR_W-1:VALUE_W]};
        end
    endgenerate

    assign busy = (r_state != ST_IDLE);
    assign done = w_done;
    assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_driver
//  Description : Shows a binary value as decimal on a multiplexed,
//                active-low 7-segment display. scan_clk is sampled as data;
//                each rising edge advances to the next digit.
//  Ports       : clk_in      - system clock
//                reset       - synchronous active-high reset
//                scan_clk    - divided scan strobe (data, not a clock)
//                value       - binary value to display
//                value_valid - 1-cycle load strobe
//                busy        - conversion in progress
//                ovf         - displayed value exceeds 10^DIGITS-1
//                an          - anode enables, active-low one-hot
//                seg         - segments {g,f,e,d,c,b,a}, active-low
//                dp          - decimal point, always off
//  Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int VALUE_W  = 16,
    parameter int DIGITS   = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic                scan_clk,
    input  logic [VALUE_W-1:0]  value,
    input  logic                value_valid,
    output logic                busy,
    output logic                ovf,
    output logic [DIGITS-1:0]   an,
    output logic [6:0]          seg,
    output logic                dp
);

    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);

    logic                   r_scan_q;
    logic                   w_scan_tick;
    logic [c_IDX_W-1:0]     r_digit_idx;
    logic [DIGITS*4-1:0]    r_disp;
    logic [DIGITS*4-1:0]    w_bcd;
    logic                   w_done;
    logic                   w_ovf;
    logic [DIGITS-1:0]      w_nz;
    logic                   w_blank;
    logic [3:0]             w_nib;
    logic [6:0]             w_seg_next;
    logic [DIGITS-1:0]      w_an_next;
    logic [DIGITS-1:0]      r_an;
    logic [6:0]             r_seg;

    bin2bcd_seq #(
        .VALUE_W (VALUE_W),
        .DIGITS  (DIGITS)
    ) u_bin2bcd (
        .clk_in  (clk_in),
        .reset   (reset),
        .start   (value_valid),
        .value   (value),
        .busy    (busy),
        .done    (w_done),
        .bcd     (w_bcd),
        .ovf     (w_ovf)
    );

    assign w_scan_tick = scan_clk & ~r_scan_q;

    // A digit is a leading zero when no nonzero nibble sits at or above it.
    always_comb begin
        w_nz = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_nz[i] = |r_disp[4*i +: 4];
        end
    end

    always_comb begin
        w_nib      = r_disp[{r_digit_idx, 2'b00} +: 4];
        w_blank    = (BLANK_LZ != 0) && (r_digit_idx != '0) &&
                     ((w_nz >> r_digit_idx) == '0);
        w_an_next  = ~(DIGITS'(1) << r_digit_idx);
        if (w_ovf) begin
            w_seg_next = SEG_DASH;
        end else if (w_blank) begin
            w_seg_next = SEG_BLANK;
        end else begin
            w_seg_next = hex_to_seg(w_nib);
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_scan_q    <= 1'b0;
            r_digit_idx <= '0;
            r_an        <= '1;
            r_seg       <= SEG_BLANK;
            r_disp      <= '0;
        end else begin
            r_scan_q <= scan_clk;
            if (w_scan_tick) begin
                r_an        <= w_an_next;
                r_seg       <= w_seg_next;
                r_digit_idx <= (r_digit_idx == c_IDX_LAST) ? '0 : r_digit_idx + 1'b1;
            end
            // Display register only ever changes as a whole, at conversion end.
            if (w_done) begin
                r_disp <= w_bcd;
            end
        end
    end

    assign ovf = w_ovf;
    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_driver
//  Description : Scoreboard bench for seg7_scan_driver. A cycle driver feeds
//                a decimal-display reference model and queues expectations;
//                a monitor compares busy/ovf every cycle and an/seg whenever
//                a new digit is presented.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int VALUE_W = 16;
    localparam int DIGITS  = 4;
    localparam int LAT     = VALUE_W + 1;

    logic        clk_in      = 1'b0;
    logic        reset       = 1'b1;
    logic        scan_clk    = 1'b0;
    logic [15:0] value       = '0;
    logic        value_valid = 1'b0;
    logic        busy;
    logic        ovf;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 clk_in = ~clk_in;

    seg7_scan_driver #(
        .VALUE_W  (VALUE_W),
        .DIGITS   (DIGITS),
        .BLANK_LZ (1)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .scan_clk    (scan_clk),
        .value       (value),
        .value_valid (value_valid),
        .busy        (busy),
        .ovf         (ovf),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [1:0]  q_stat[$];   // {busy, ovf} expected after each clock
    logic [10:0] q_disp[$];   // {an, seg} expected per scan tick

    logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int unsigned p10 [5] = '{1, 10, 100, 1000, 10000};

    // Reference model: display value, conversion in flight, pending slot.
    int          cyc = 0;
    int unsigned m_disp = 0;
    int unsigned m_conv = 0;
    int unsigned m_pend_val = 0;
    bit          m_active = 0;
    bit          m_pending = 0;
    int          m_end = 0;
    int          m_idx = 0;
    bit          m_scan_prev = 0;

    function automatic logic [6:0] exp_seg(input int unsigned v, input int k);
        if (v > 9999)             return 7'h3F;
        if (k > 0 && v < p10[k])  return 7'h7F;
        return seg_tab[(v / p10[k]) % 10];
    endfunction

    function automatic logic [3:0] exp_an(input int k);
        logic [3:0] a;
        a    = 4'hF;
        a[k] = 1'b0;
        return a;
    endfunction

    task automatic step(input logic rst, input logic strobe,
                        input logic [15:0] val, input logic scan);
        @(negedge clk_in);
        reset       = rst;
        value_valid = strobe;
        value       = val;
        scan_clk    = scan;
        if (rst) begin
            m_active    = 0;
            m_pending   = 0;
            m_disp      = 0;
            m_idx       = 0;
            m_scan_prev = 0;
            q_stat.push_back(2'b00);
        end else begin
            if (scan && !m_scan_prev) begin
                q_disp.push_back({exp_an(m_idx), exp_seg(m_disp, m_idx)});
                m_idx = (m_idx + 1) % DIGITS;
            end
            m_scan_prev = scan;
            if (m_active && cyc == m_end) begin
                m_disp = m_conv;
                if (m_pending) begin
                    m_conv    = m_pend_val;
                    m_end     = cyc + LAT;
                    m_pending = 0;
                end else begin
                    m_active = 0;
                end
            end
            if (strobe) begin
                if (!m_active) begin
                    m_active = 1;
                    m_conv   = val;
                    m_end    = cyc + LAT;
                end else begin
                    m_pending  = 1;
                    m_pend_val = val;
                end
            end
            q_stat.push_back({m_active, (m_disp > 9999) ? 1'b1 : 1'b0});
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'd0, 1'b0);
    endtask

    task automatic scan_pulse();
        step(1'b0, 1'b0, 16'd0, 1'b1);
        step(1'b0, 1'b0, 16'd0, 1'b0);
    endtask

    task automatic show_all();
        for (int i = 0; i < DIGITS; i++) scan_pulse();
    endtask

    task automatic convert(input logic [15:0] v);
        step(1'b0, 1'b1, v, 1'b0);
        idle(LAT + 1);
    endtask

    task automatic check1(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor
    initial begin : monitor
        logic [3:0]  prev_an;
        logic [1:0]  es;
        logic [10:0] ed;
        prev_an = 4'hF;
        forever begin
            @(posedge clk_in);
            #1;
            if (q_stat.size() > 0) begin
                es = q_stat.pop_front();
                n_vec++;
                if ({busy, ovf} !== es) begin
                    n_err++;
                    $display("FAIL status @%0t: busy,ovf got %b%b expected %b", $time, busy, ovf, es);
                end
            end
            if (an !== prev_an) begin
                if (an !== 4'hF) begin
                    n_vec++;
                    if (q_disp.size() == 0) begin
                        n_err++;
                        $display("FAIL scan @%0t: unexpected digit update an=%b seg=%h expected none", $time, an, seg);
                    end else begin
                        ed = q_disp.pop_front();
                        if ({an, seg} !== ed) begin
                            n_err++;
                            $display("FAIL scan @%0t: an/seg got %b/%h expected %b/%h", $time, an, seg, ed[10:7], ed[6:0]);
                        end
                    end
                end
                prev_an = an;
            end
        end
    end

    // Driver
    initial begin : driver
        int unsigned r;
        logic [15:0] v;
        step(1'b1, 1'b0, 16'd0, 1'b0);
        step(1'b1, 1'b0, 16'd0, 1'b0);
        idle(2);
        scan_pulse();                       // digit 0 shows "0"

        // Reset in the middle of a conversion
        step(1'b0, 1'b1, 16'd1234, 1'b0);
        idle(5);
        step(1'b1, 1'b0, 16'd0, 1'b0);
        @(posedge clk_in);
        #2;
        check1("reset_busy", {7'd0, busy}, 8'h00);
        check1("reset_an",   {4'd0, an},   8'h0F);
        check1("reset_seg",  {1'b0, seg},  8'h7F);
        check1("reset_dp",   {7'd0, dp},   8'h01);
        idle(2);
        scan_pulse();                       // display register is 0 again

        convert(16'd1234);  show_all();
        convert(16'd7);     show_all();
        convert(16'd0);     show_all();
        convert(16'd10000); show_all();
        convert(16'd9999);  show_all();

        // Back-to-back strobes: 22 is overwritten by 33 in the pending slot
        step(1'b0, 1'b1, 16'd11, 1'b0);
        idle(2);
        step(1'b0, 1'b1, 16'd22, 1'b0);
        idle(1);
        step(1'b0, 1'b1, 16'd33, 1'b0);
        for (int i = 0; i < 12; i++) begin
            scan_pulse();
            idle(1);
        end
        idle(6);
        show_all();

        // Strobe in the same cycle the previous conversion finishes
        step(1'b0, 1'b1, 16'd4321, 1'b0);
        idle(LAT - 1);
        step(1'b0, 1'b1, 16'd58, 1'b0);
        idle(LAT + 1);
        show_all();

        // scan_clk held high: exactly one advance; then a 1-cycle pulse
        for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 16'd0, 1'b1);
        idle(3);
        scan_pulse();
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            r = $urandom_range(0, 2);
            case (r)
                0:       v = 16'($urandom);
                1:       v = 16'($urandom_range(0, 120));
                default: v = 16'($urandom_range(9985, 10015));
            endcase
            step(($urandom_range(0, 599) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
                 v,
                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
        end

        idle(2 * LAT + 5);
        show_all();
        idle(4);

        while (q_disp.size() > 0) begin
            void'(q_disp.pop_front());
            n_vec++;
            n_err++;
            $display("FAIL scan_missing: got no digit update expected one");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
